// File: rtl/i2c_target_responder.sv
// I2C target that answers a bus master at SLAVE_ADDR: writes stream out on a rx valid/ready port,
// reads are served from a tx valid/ready port. SCL is never stretched.
module i2c_target_responder #(
    parameter int                        I2C_ADDR_WIDTH = 7,
    parameter int                        I2C_DATA_WIDTH = 8,
    parameter logic [I2C_ADDR_WIDTH-1:0] SLAVE_ADDR     = 7'h12,
    parameter int                        FILTER_LEN     = 3
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      scl_i,
    input  logic                      sda_i,
    output logic                      sda_o,
    output logic [I2C_DATA_WIDTH-1:0] rx_data_o,
    output logic                      rx_valid_o,
    input  logic                      rx_ready_i,
    input  logic [I2C_DATA_WIDTH-1:0] tx_data_i,
    input  logic                      tx_valid_i,
    output logic                      tx_ready_o,
    output logic                      start_o,
    output logic                      stop_o,
    output logic                      busy_o,
    output logic                      rw_o,
    output logic                      err_o
);

    localparam int          FCW  = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
    localparam logic [2:0]  LAST = 3'd7;
    localparam int          DW   = I2C_DATA_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_IGNORE
    } state_t;

    // Bit 0 carries SCL, bit 1 carries SDA through the conditioning chain.
    logic [1:0]     r_sync1, r_sync2, r_filt, r_filt_d;
    logic [FCW-1:0] r_fcnt [2];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_sync1   <= 2'b11;
            r_sync2   <= 2'b11;
            r_filt    <= 2'b11;
            r_filt_d  <= 2'b11;
            r_fcnt[0] <= '0;
            r_fcnt[1] <= '0;
        end else begin
            r_sync1  <= {sda_i, scl_i};
            r_sync2  <= r_sync1;
            r_filt_d <= r_filt;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_filt[i]) begin
                    r_fcnt[i] <= '0;
                end else if (r_fcnt[i] == FCW'(FILTER_LEN - 1)) begin
                    r_filt[i] <= r_sync2[i];
                    r_fcnt[i] <= '0;
                end else begin
                    r_fcnt[i] <= r_fcnt[i] + FCW'(1);
                end
            end
        end
    end

    logic w_scl, w_sda, w_scl_rise, w_scl_fall, w_sda_rise, w_sda_fall, w_start, w_stop;
    assign w_scl      = r_filt[0];
    assign w_sda      = r_filt[1];
    assign w_scl_rise =  r_filt[0] & ~r_filt_d[0];
    assign w_scl_fall = ~r_filt[0] &  r_filt_d[0];
    assign w_sda_rise =  r_filt[1] & ~r_filt_d[1];
    assign w_sda_fall = ~r_filt[1] &  r_filt_d[1];
    assign w_start    = w_sda_fall & w_scl;
    assign w_stop     = w_sda_rise & w_scl;

    state_t          r_state;
    logic [2:0]      r_bitcnt;
    logic [DW-1:0]   r_shift, r_tx, r_rx_data;
    logic            r_done, r_ack, r_rw, r_sda_o;
    logic            r_rx_valid, r_tx_ready, r_start, r_stop, r_busy, r_err;

    logic [DW-1:0] w_byte, w_tx_byte;
    logic          w_match;
    assign w_byte    = {r_shift[DW-2:0], w_sda};
    assign w_match   = (w_byte[DW-1 -: I2C_ADDR_WIDTH] == SLAVE_ADDR);
    // An empty tx source is answered with all-ones (bus idles high) and flagged.
    assign w_tx_byte = tx_valid_i ? tx_data_i : '1;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= S_IDLE;
            r_bitcnt   <= '0;
            r_shift    <= '0;
            r_tx       <= '1;
            r_rx_data  <= '0;
            r_done     <= 1'b0;
            r_ack      <= 1'b0;
            r_rw       <= 1'b0;
            r_sda_o    <= 1'b1;
            r_rx_valid <= 1'b0;
            r_tx_ready <= 1'b0;
            r_start    <= 1'b0;
            r_stop     <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_tx_ready <= 1'b0;
            r_start    <= 1'b0;
            r_stop     <= 1'b0;
            r_err      <= 1'b0;
            // The sink's ready is judged in the cycle the byte is presented.
            if (r_rx_valid) begin
                r_ack <= rx_ready_i;
                r_err <= ~rx_ready_i;
            end
            if (w_start) begin
                r_state  <= S_ADDR;
                r_bitcnt <= '0;
                r_sda_o  <= 1'b1;
                r_done   <= 1'b0;
                r_start  <= 1'b1;
                r_busy   <= 1'b1;
            end else if (w_stop) begin
                r_state <= S_IDLE;
                r_sda_o <= 1'b1;
                r_done  <= 1'b0;
                r_stop  <= 1'b1;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift  <= w_byte;
                            r_bitcnt <= r_bitcnt + 3'd1;
                            if (r_bitcnt == LAST) begin
                                if (w_match) begin
                                    r_rw   <= w_sda;
                                    r_done <= 1'b1;
                                end else begin
                                    r_state <= S_IGNORE;
                                end
                            end
                        end else if (w_scl_fall && r_done) begin
                            r_sda_o <= 1'b0;
                            r_done  <= 1'b0;
                            r_state <= S_ADDR_ACK;
                        end
                    end
                    S_ADDR_ACK: begin
                        if (w_scl_fall) begin
                            r_bitcnt <= '0;
                            if (!r_rw) begin
                                r_sda_o <= 1'b1;
                                r_state <= S_WR_DATA;
                            end else begin
                                r_sda_o    <= w_tx_byte[DW-1];
                                r_tx       <= {w_tx_byte[DW-2:0], 1'b1};
                                r_tx_ready <= tx_valid_i;
                                r_err      <= ~tx_valid_i;
                                r_state    <= S_RD_DATA;
                            end
                        end
                    end
                    S_WR_DATA: begin
                        if (w_scl_rise) begin
                            r_shift  <= w_byte;
                            r_bitcnt <= r_bitcnt + 3'd1;
                            if (r_bitcnt == LAST) begin
                                r_rx_data  <= w_byte;
                                r_rx_valid <= 1'b1;
                                r_done     <= 1'b1;
                            end
                        end else if (w_scl_fall && r_done) begin
                            r_sda_o <= ~r_ack;
                            r_done  <= 1'b0;
                            r_state <= S_WR_ACK;
                        end
                    end
                    S_WR_ACK: begin
                        if (w_scl_fall) begin
                            r_sda_o <= 1'b1;
                            r_state <= S_WR_DATA;
                        end
                    end
                    S_RD_DATA: begin
                        if (w_scl_fall) begin
                            if (r_bitcnt == LAST) begin
                                r_sda_o  <= 1'b1;
                                r_bitcnt <= '0;
                                r_state  <= S_RD_ACK;
                            end else begin
                                r_sda_o  <= r_tx[DW-1];
                                r_tx     <= {r_tx[DW-2:0], 1'b1};
                                r_bitcnt <= r_bitcnt + 3'd1;
                            end
                        end
                    end
                    S_RD_ACK: begin
                        if (w_scl_rise && w_sda) begin
                            r_state <= S_IGNORE;
                        end else if (w_scl_fall) begin
                            r_sda_o    <= w_tx_byte[DW-1];
                            r_tx       <= {w_tx_byte[DW-2:0], 1'b1};
                            r_tx_ready <= tx_valid_i;
                            r_err      <= ~tx_valid_i;
                            r_bitcnt   <= '0;
                            r_state    <= S_RD_DATA;
                        end
                    end
                    default: begin
                        r_sda_o <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign sda_o      = r_sda_o;
    assign rx_data_o  = r_rx_data;
    assign rx_valid_o = r_rx_valid;
    assign tx_ready_o = r_tx_ready;
    assign start_o    = r_start;
    assign stop_o     = r_stop;
    assign busy_o     = r_busy;
    assign rw_o       = r_rw;
    assign err_o      = r_err;

endmodule

// File: tb/tb_i2c_target_responder.sv
// Bench for i2c_target_responder: a bit-level I2C master drives the bus while
// queues hold the bytes expected on the rx port and on the bus during reads.
module tb_i2c_target_responder;

    localparam int Q = 10;

    logic       clk = 1'b0;
    logic       rst_i = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       rx_ready_i = 1'b1;
    logic       tx_valid_i = 1'b0;
    logic [7:0] tx_data_i = 8'h00;
    logic       sda_o, rx_valid_o, tx_ready_o, start_o, stop_o, busy_o, rw_o, err_o;
    logic [7:0] rx_data_o;
    logic       sda_line;

    assign sda_line = m_sda & sda_o;

    i2c_target_responder dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .scl_i     (m_scl),
        .sda_i     (sda_line),
        .sda_o     (sda_o),
        .rx_data_o (rx_data_o),
        .rx_valid_o(rx_valid_o),
        .rx_ready_i(rx_ready_i),
        .tx_data_i (tx_data_i),
        .tx_valid_i(tx_valid_i),
        .tx_ready_o(tx_ready_o),
        .start_o   (start_o),
        .stop_o    (stop_o),
        .busy_o    (busy_o),
        .rw_o      (rw_o),
        .err_o     (err_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt_rx = 0, cnt_txr = 0, cnt_err = 0, cnt_start = 0, cnt_stop = 0;
    logic [7:0] exp_rx[$];
    logic [7:0] exp_bus[$];
    logic [7:0] tx_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor and tx source, both working away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rx_valid_o && rx_ready_i) begin
                cnt_rx++;
                if (exp_rx.size() == 0) check_eq("rx_unexpected", {24'd0, rx_data_o}, 32'h1ff);
                else check_eq("rx_data", {24'd0, rx_data_o}, {24'd0, exp_rx.pop_front()});
            end
            if (err_o)   cnt_err++;
            if (start_o) cnt_start++;
            if (stop_o)  cnt_stop++;
            if (tx_ready_o) begin
                cnt_txr++;
                if (tx_q.size() > 0) void'(tx_q.pop_front());
            end
            tx_valid_i = (tx_q.size() > 0);
            tx_data_i  = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clk_bit(input logic b, output logic s);
        wait_clk(Q); m_sda = b;
        wait_clk(Q); m_scl = 1'b1;
        wait_clk(Q); s = sda_line;
        wait_clk(Q); m_scl = 1'b0;
    endtask

    task automatic bus_start();
        m_sda = 1'b0;
        wait_clk(2 * Q);
        m_scl = 1'b0;
    endtask

    task automatic bus_rep_start();
        wait_clk(Q); m_sda = 1'b1;
        wait_clk(Q); m_scl = 1'b1;
        wait_clk(2 * Q); m_sda = 1'b0;
        wait_clk(2 * Q); m_scl = 1'b0;
    endtask

    task automatic bus_stop();
        wait_clk(Q); m_sda = 1'b0;
        wait_clk(Q); m_scl = 1'b1;
        wait_clk(2 * Q); m_sda = 1'b1;
        wait_clk(2 * Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
        clk_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, s);
            b[i] = s;
        end
        clk_bit(nack, s);
    endtask

    initial begin
        logic       ack, s;
        logic [7:0] rb;
        int         rx0, tx0, err0, st0;

        // Reset state
        wait_clk(4);
        check_eq("rst_sda", {31'd0, sda_o}, 32'd1);
        check_eq("rst_busy", {31'd0, busy_o}, 32'd0);
        check_eq("rst_rw", {31'd0, rw_o}, 32'd0);
        check_eq("rst_rxdata", {24'd0, rx_data_o}, 32'd0);
        check_eq("rst_strobes", {26'd0, rx_valid_o, tx_ready_o, start_o, stop_o, err_o, 1'b0}, 32'd0);
        rst_i = 1'b1;
        wait_clk(20);

        // 1: 32-byte write
        rx0 = cnt_rx; err0 = cnt_err;
        bus_start();
        write_byte(8'h24, ack);
        check_eq("t1_addr_ack", {31'd0, ack}, 32'd0);
        check_eq("t1_busy", {31'd0, busy_o}, 32'd1);
        for (int i = 0; i < 32; i++) begin
            exp_rx.push_back(8'(i));
            write_byte(8'(i), ack);
            check_eq("t1_data_ack", {31'd0, ack}, 32'd0);
        end
        bus_stop();
        check_eq("t1_rx_count", cnt_rx - rx0, 32);
        check_eq("t1_err", cnt_err - err0, 0);
        check_eq("t1_busy_after", {31'd0, busy_o}, 32'd0);
        check_eq("t1_rw", {31'd0, rw_o}, 32'd0);

        // 2: 4-byte read, NACK on last
        tx0 = cnt_txr; err0 = cnt_err;
        for (int i = 0; i < 4; i++) begin
            tx_q.push_back(8'h64 + 8'(i));
            exp_bus.push_back(8'h64 + 8'(i));
        end
        wait_clk(4);
        bus_start();
        write_byte(8'h25, ack);
        check_eq("t2_addr_ack", {31'd0, ack}, 32'd0);
        check_eq("t2_rw", {31'd0, rw_o}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            read_byte(i == 3, rb);
            check_eq("t2_rd_byte", {24'd0, rb}, {24'd0, exp_bus.pop_front()});
        end
        wait_clk(Q);
        check_eq("t2_sda_released", {31'd0, sda_o}, 32'd1);
        bus_stop();
        check_eq("t2_tx_ready_count", cnt_txr - tx0, 4);
        check_eq("t2_err", cnt_err - err0, 0);

        // 3: wrong address
        rx0 = cnt_rx; tx0 = cnt_txr;
        bus_start();
        write_byte(8'h26, ack);
        check_eq("t3_addr_nack", {31'd0, ack}, 32'd1);
        write_byte(8'h55, ack);
        check_eq("t3_ignore_nack", {31'd0, ack}, 32'd1);
        check_eq("t3_busy", {31'd0, busy_o}, 32'd1);
        bus_stop();
        check_eq("t3_rx_count", cnt_rx - rx0, 0);
        check_eq("t3_tx_count", cnt_txr - tx0, 0);
        check_eq("t3_busy_after", {31'd0, busy_o}, 32'd0);

        // 4: sink not ready on the third byte
        rx0 = cnt_rx; err0 = cnt_err;
        bus_start();
        write_byte(8'h24, ack);
        check_eq("t4_addr_ack", {31'd0, ack}, 32'd0);
        exp_rx.push_back(8'hA1);
        write_byte(8'hA1, ack);
        check_eq("t4_ack1", {31'd0, ack}, 32'd0);
        exp_rx.push_back(8'hA2);
        write_byte(8'hA2, ack);
        check_eq("t4_ack2", {31'd0, ack}, 32'd0);
        rx_ready_i = 1'b0;
        write_byte(8'hA3, ack);
        rx_ready_i = 1'b1;
        check_eq("t4_nack3", {31'd0, ack}, 32'd1);
        bus_stop();
        check_eq("t4_rx_count", cnt_rx - rx0, 2);
        check_eq("t4_err_count", cnt_err - err0, 1);

        // 5: write, repeated START, read
        rx0 = cnt_rx; st0 = cnt_start; tx0 = cnt_txr;
        tx_q.push_back(8'h5A);
        exp_bus.push_back(8'h5A);
        bus_start();
        write_byte(8'h24, ack);
        check_eq("t5_waddr_ack", {31'd0, ack}, 32'd0);
        exp_rx.push_back(8'hAB);
        write_byte(8'hAB, ack);
        check_eq("t5_wdata_ack", {31'd0, ack}, 32'd0);
        bus_rep_start();
        check_eq("t5_busy_rs", {31'd0, busy_o}, 32'd1);
        write_byte(8'h25, ack);
        check_eq("t5_raddr_ack", {31'd0, ack}, 32'd0);
        read_byte(1'b1, rb);
        check_eq("t5_rd_byte", {24'd0, rb}, {24'd0, exp_bus.pop_front()});
        check_eq("t5_busy_pre_stop", {31'd0, busy_o}, 32'd1);
        bus_stop();
        check_eq("t5_start_count", cnt_start - st0, 2);
        check_eq("t5_rx_count", cnt_rx - rx0, 1);
        check_eq("t5_tx_count", cnt_txr - tx0, 1);
        check_eq("t5_busy_after", {31'd0, busy_o}, 32'd0);

        // 6: reset while the address ACK is being driven
        bus_start();
        for (int i = 7; i >= 0; i--) clk_bit(rb[0] ^ rb[0] ^ ((8'h24 >> i) & 1), s);
        wait_clk(Q);
        m_sda = 1'b1;
        wait_clk(2);
        check_eq("t6_ack_driven", {31'd0, sda_o}, 32'd0);
        #3 rst_i = 1'b0;
        #1 check_eq("t6_async_release", {31'd0, sda_o}, 32'd1);
        check_eq("t6_busy_rst", {31'd0, busy_o}, 32'd0);
        wait_clk(2);
        m_scl = 1'b1;
        m_sda = 1'b1;
        wait_clk(4);
        rst_i = 1'b1;
        wait_clk(20);
        rx0 = cnt_rx;
        bus_start();
        write_byte(8'h24, ack);
        check_eq("t6_addr_ack", {31'd0, ack}, 32'd0);
        exp_rx.push_back(8'h3C);
        write_byte(8'h3C, ack);
        check_eq("t6_data_ack", {31'd0, ack}, 32'd0);
        bus_stop();
        check_eq("t6_rx_count", cnt_rx - rx0, 1);

        check_eq("rx_queue_empty", exp_rx.size(), 0);
        check_eq("tx_queue_empty", tx_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
